logic_sweep_ctrl: RTL and testbench

- Sequencer for the 4-input / 3-output combinational logic_function block (inputs x1..x4; outputs y1..y3 and complements y1inv..y3inv).
- Drives every input combination onto the block, waits a programmable settle time, then captures the outputs into a 16-entry result store.
- Checks each output pair for complementarity (y ^ yinv == all ones) and counts violations.
- Replaces free-running toggle stimulus with a deterministic, clocked sweep for on-board self-test.

---
 rtl/logic_sweep_ctrl.sv | 137 +++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sweep_ctrl.sv
// Clocked self-test sequencer for the 4-in / 3-out logic_function block: sweeps x, captures y, checks y/yinv complementarity.
// Optional build macro LOGIC_SWEEP_GRAY_EN selects Gray-order application of the full sweep.
module logic_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_OUT       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               single,
    input  logic [3:0]         sel_vec,
    output logic [3:0]         x,
    input  logic [NUM_OUT-1:0] y_in,
    input  logic [NUM_OUT-1:0] yinv_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [4:0]         err_count,
    input  logic [3:0]         rd_addr,
    output logic [NUM_OUT-1:0] rd_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRIVE   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [NUM_OUT-1:0] ALL_ONES    = {NUM_OUT{1'b1}};

    function automatic logic [3:0] f_sweep_vec(input logic [3:0] cnt);
`ifdef LOGIC_SWEEP_GRAY_EN
        f_sweep_vec = cnt ^ {1'b0, cnt[3:1]};
`else
        f_sweep_vec = cnt;
`endif
    endfunction

    logic [2:0]         r_state;
    logic [3:0]         r_cnt;
    logic [3:0]         r_settle;
    logic [3:0]         r_x;
    logic               r_single;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [4:0]         r_err_count;
    logic [NUM_OUT-1:0] r_result [16];

    logic               w_viol;
    logic [3:0]         w_cnt_nxt;

    assign w_viol    = ((y_in ^ yinv_in) != ALL_ONES);
    assign w_cnt_nxt = r_cnt + 4'd1;

    // Sweep sequencer: x is loaded on the edge entering DRIVE so it is already applied during DRIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_settle    <= 4'd0;
            r_x         <= 4'd0;
            r_single    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                r_result[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_DRIVE;
                        r_busy      <= 1'b1;
                        r_single    <= single;
                        r_err       <= 1'b0;
                        r_err_count <= 5'd0;
                        r_cnt       <= single ? sel_vec : 4'd0;
                        r_x         <= single ? sel_vec : f_sweep_vec(4'd0);
                    end
                end
                S_DRIVE: begin
                    if (SETTLE_CYCLES == 0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_state  <= S_SETTLE;
                        r_settle <= SETTLE_LOAD - 4'd1;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == 4'd0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_result[r_x] <= y_in;
                    if (w_viol) begin
                        r_err <= 1'b1;
                        if (r_err_count < 5'd16) begin
                            r_err_count <= r_err_count + 5'd1;
                        end
                    end
                    if (r_single || (r_cnt == 4'd15)) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                        r_x     <= f_sweep_vec(w_cnt_nxt);
                        r_state <= S_DRIVE;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x         = r_x;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign rd_data   = r_result[rd_addr];

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Scoreboard bench for logic_sweep_ctrl: a behavioural logic_function model feeds y/yinv, a monitor checks each done pulse.
module tb_logic_sweep_ctrl;

    localparam int S          = 2;
    localparam int LAT_FULL   = 16 * (S + 2) + 1;
    localparam int LAT_SINGLE = S + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       single = 1'b0;
    logic [3:0] sel_vec = 4'd0;
    logic [3:0] rd_addr = 4'd0;
    logic [3:0] x;
    logic [2:0] y_in;
    logic [2:0] yinv_in;
    logic [2:0] rd_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] err_count;
    logic [15:0] inj = 16'd0;

    logic_sweep_ctrl #(.SETTLE_CYCLES(S), .NUM_OUT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .single(single), .sel_vec(sel_vec),
        .x(x), .y_in(y_in), .yinv_in(yinv_in), .busy(busy), .done(done),
        .err(err), .err_count(err_count), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] model_y(input logic [3:0] v);
        return {v[3] & v[2], v[1] | v[0], v[3] ^ v[0]};
    endfunction

    function automatic logic [3:0] exp_vec(input int i);
        logic [3:0] c;
        c = 4'(i);
`ifdef LOGIC_SWEEP_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    // The modelled logic_function block, with optional complement fault per vector.
    always_comb begin
        y_in    = model_y(x);
        yinv_in = ~model_y(x);
        if (inj[x]) yinv_in[0] = y_in[0];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int exp_cyc;
        int exp_err;
        int exp_cnt;
        int is_single;
        int sel;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] mem [16];

    // Monitor: records applied vectors and checks every done pulse against the scoreboard.
    initial begin
        logic [3:0] xq[$];
        logic [3:0] prev_x;
        logic       prev_busy;
        exp_t       e;
        int         ok;
        prev_x = 4'd0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                xq.delete();
                prev_busy = 1'b0;
            end else begin
                if (busy && (!prev_busy || x != prev_x)) xq.push_back(x);
                prev_busy = busy;
                prev_x = x;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL done_unexpected: got done=1 at cycle %0d, expected no pulse", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_cycle", cyc, e.exp_cyc);
                        chk("err", err, e.exp_err);
                        chk("err_count", err_count, e.exp_cnt);
                        chk("busy_at_done", busy, 0);
                        ok = (xq.size() == (e.is_single != 0 ? 1 : 16)) ? 1 : 0;
                        for (int i = 0; i < xq.size(); i++) begin
                            if (ok != 0 && xq[i] != (e.is_single != 0 ? 4'(e.sel) : exp_vec(i))) ok = 0;
                        end
                        chk("x_sequence", ok, 1);
`ifdef LOGIC_SWEEP_GRAY_EN
                        if (e.is_single == 0) begin
                            ok = (xq.size() == 16) ? 1 : 0;
                            for (int i = 1; i < xq.size(); i++) begin
                                if ($countones(xq[i] ^ xq[i-1]) != 1) ok = 0;
                            end
                            chk("gray_hamming", ok, 1);
                        end
`endif
                        xq.delete();
                    end
                end
            end
        end
    end

    task automatic issue(input logic sgl, input logic [3:0] sv);
        exp_t e;
        e.is_single = sgl ? 1 : 0;
        e.sel       = int'(sv);
        e.exp_cyc   = cyc + 1 + (sgl ? LAT_SINGLE : LAT_FULL);
        e.exp_cnt   = sgl ? int'(inj[sv]) : $countones(inj);
        e.exp_err   = (e.exp_cnt != 0) ? 1 : 0;
        sb_q.push_back(e);
        if (sgl) begin
            mem[sv] = model_y(sv);
        end else begin
            for (int a = 0; a < 16; a++) mem[a] = model_y(4'(a));
        end
        start   = 1'b1;
        single  = sgl;
        sel_vec = sv;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk("done_within_budget", done, 1);
    endtask

    task automatic check_results();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk("rd_data", rd_data, mem[a]);
        end
    endtask

    task automatic run_sweep(input logic sgl, input logic [3:0] sv, input logic [15:0] mask, input logic pulses);
        @(posedge clk); #1;
        inj = mask;
        issue(sgl, sv);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (pulses && !sgl) begin
            repeat (9) @(posedge clk);
            #1 start = 1'b1; single = 1'($urandom); sel_vec = 4'($urandom);
            @(posedge clk); #1 start = 1'b0;
            repeat (29) @(posedge clk);
            #1 start = 1'b1; single = 1'($urandom); sel_vec = 4'($urandom);
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(LAT_FULL + 20);
        check_results();
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_x", x, 0);
        check_results();

        run_sweep(1'b0, 4'd0, 16'h0000, 1'b0);
        run_sweep(1'b0, 4'd0, 16'h0420, 1'b1);
        run_sweep(1'b1, 4'hC, 16'h0000, 1'b0);

        // Reset in the middle of a full sweep: no done, everything cleared.
        @(posedge clk); #1;
        inj = 16'h0000;
        issue(1'b0, 4'd0);
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_x", x, 0);
        chk("midrst_err", err, 0);
        for (int a = 0; a < 16; a++) mem[a] = 3'd0;
        check_results();
        repeat (80) @(posedge clk);
        run_sweep(1'b0, 4'd0, 16'h0000, 1'b0);

        // Start held high through FINISH: the next sweep begins on the first IDLE cycle.
        @(posedge clk); #1;
        inj = 16'h8001;
        issue(1'b0, 4'd0);
        wait_done(LAT_FULL + 20);
        inj = 16'h0000;
        issue(1'b0, 4'd0);
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("held_start_err_cleared", err, 0);
        chk("held_start_busy", busy, 1);
        wait_done(LAT_FULL + 20);
        check_results();

        repeat (12) begin
            run_sweep(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom & $urandom),
                      1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
